// File: rtl/int_img_stream_if.sv
// Pixel-in / integral-image-out bundle for int_img_stream.
// master = pixel producer and image consumer side, slave = the integral image writer.
interface int_img_stream_if #(
    parameter int WIDTH  = 24,
    parameter int HEIGHT = 24,
    parameter int PIX_W  = 8
);
    logic [PIX_W-1:0]                   pix_in;
    logic                               pix_valid;
    logic                               pix_ready;
    logic                               frame_clr;
    logic [HEIGHT-1:0][WIDTH-1:0][31:0] int_img;
    logic [HEIGHT-1:0][WIDTH-1:0][31:0] int_img_sq;
    logic                               img_valid;
    logic                               img_ready;

    modport master (
        output pix_in, pix_valid, frame_clr, img_ready,
        input  pix_ready, int_img, int_img_sq, img_valid
    );

    modport slave (
        input  pix_in, pix_valid, frame_clr, img_ready,
        output pix_ready, int_img, int_img_sq, img_valid
    );
endinterface

// File: rtl/int_img_stream.sv
// Streaming writer of the inclusive integral and squared integral image of one window.
// Each accepted raster pixel updates exactly one cell using the running row sum and the cell above.
module int_img_stream #(
    parameter int WIDTH  = 24,
    parameter int HEIGHT = 24,
    parameter int PIX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    int_img_stream_if.slave  bus
);
    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic {FILL, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic [31:0]   row_acc_q, row_acc_d;
    logic [31:0]   row_acc_sq_q, row_acc_sq_d;
    logic [HEIGHT-1:0][WIDTH-1:0][31:0] int_img_q, int_img_d;
    logic [HEIGHT-1:0][WIDTH-1:0][31:0] int_img_sq_q, int_img_sq_d;

    logic              acc, last_pix;
    logic [2*PIX_W-1:0] pix_ext, pix_sq;
    logic [31:0]       rs, rs2, up, up_sq;

    // Acceptance depends only on state, so pix_ready has no path from pix_valid.
    assign acc      = bus.pix_valid && (state_q == FILL) && !bus.frame_clr;
    assign last_pix = (r_q == RW'(HEIGHT-1)) && (c_q == CW'(WIDTH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (acc && last_pix) state_d = DONE;
            DONE: if (bus.img_ready)   state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        bus.pix_ready = (state_q == FILL);
        bus.img_valid = (state_q == DONE);
    end

    always_comb begin
        pix_ext = {{PIX_W{1'b0}}, bus.pix_in};
        pix_sq  = pix_ext * pix_ext;
        rs      = ((c_q == '0) ? 32'd0 : row_acc_q)    + 32'(bus.pix_in);
        rs2     = ((c_q == '0) ? 32'd0 : row_acc_sq_q) + 32'(pix_sq);
        up      = (r_q == '0) ? 32'd0 : int_img_q[r_q - 1'b1][c_q];
        up_sq   = (r_q == '0) ? 32'd0 : int_img_sq_q[r_q - 1'b1][c_q];

        c_d          = c_q;
        r_d          = r_q;
        row_acc_d    = row_acc_q;
        row_acc_sq_d = row_acc_sq_q;
        int_img_d    = int_img_q;
        int_img_sq_d = int_img_sq_q;

        if (state_q == FILL) begin
            if (bus.frame_clr) begin
                c_d          = '0;
                r_d          = '0;
                row_acc_d    = '0;
                row_acc_sq_d = '0;
            end else if (acc) begin
                int_img_d[r_q][c_q]    = rs  + up;
                int_img_sq_d[r_q][c_q] = rs2 + up_sq;
                row_acc_d              = rs;
                row_acc_sq_d           = rs2;
                if (c_q == CW'(WIDTH-1)) begin
                    c_d = '0;
                    r_d = (r_q == RW'(HEIGHT-1)) ? '0 : r_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
        end
    end

    // Image cells are only ever overwritten by a fill; no clear on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q          <= '0;
            r_q          <= '0;
            row_acc_q    <= '0;
            row_acc_sq_q <= '0;
            int_img_q    <= '0;
            int_img_sq_q <= '0;
        end else begin
            c_q          <= c_d;
            r_q          <= r_d;
            row_acc_q    <= row_acc_d;
            row_acc_sq_q <= row_acc_sq_d;
            int_img_q    <= int_img_d;
            int_img_sq_q <= int_img_sq_d;
        end
    end

    assign bus.int_img    = int_img_q;
    assign bus.int_img_sq = int_img_sq_q;
endmodule

// File: tb/tb_int_img_stream.sv
// Randomized bench for int_img_stream against a direct rectangle-sum model of the window.
module tb_int_img_stream;
  localparam int W = 24, H = 24, PW = 8;

  logic clk, rst;
  int n_vec, n_err;
  int unsigned pix [H][W];

  int_img_stream_if #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) bus ();
  int_img_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inclusive rectangle sums straight from the stored pixels.
  function automatic logic [31:0] ref_sum(input int r, input int c, input bit sq);
    logic [31:0] s = 0;
    for (int a = 0; a <= r; a++)
      for (int b = 0; b <= c; b++)
        s += sq ? 32'(pix[a][b] * pix[a][b]) : 32'(pix[a][b]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mode 0: constant val, 1: ramp, 2: random
  task automatic send_frame(input int mode, input int val, input int gap);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        pix[i][j] = (mode == 0) ? val : (mode == 1) ? ((i*W + j) % 256) : $urandom_range(255);
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        while (gap > 0 && $urandom_range(99) < gap) begin
          bus.pix_valid = 1'b0;
          bus.pix_in    = PW'($urandom);
          tick();
        end
        if (i == 0 && j == 0) chk("first_pix_ready", 32'(bus.pix_ready), 1);
        if (i == H-1 && j == W-1) chk("vld_before_last", 32'(bus.img_valid), 0);
        bus.pix_valid = 1'b1;
        bus.pix_in    = PW'(pix[i][j]);
        tick();
      end
    bus.pix_valid = 1'b0;
    chk("vld_after_last", 32'(bus.img_valid), 1);
    chk("rdy_after_last", 32'(bus.pix_ready), 0);
  endtask

  task automatic check_image();
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        chk($sformatf("img[%0d][%0d]", i, j), bus.int_img[i][j], ref_sum(i, j, 0));
        chk($sformatf("sq[%0d][%0d]", i, j), bus.int_img_sq[i][j], ref_sum(i, j, 1));
      end
  endtask

  task automatic release_img();
    bus.img_ready = 1'b1;
    tick();
    bus.img_ready = 1'b0;
    chk("rel_vld", 32'(bus.img_valid), 0);
    chk("rel_rdy", 32'(bus.pix_ready), 1);
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = PW'($urandom);
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask

  // Assert rst between edges and check the outputs before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_vld"}, 32'(bus.img_valid), 0);
    chk({tag, "_rdy"}, 32'(bus.pix_ready), 1);
    chk({tag, "_img00"}, bus.int_img[0][0], 0);
    chk({tag, "_img_end"}, bus.int_img[H-1][W-1], 0);
    chk({tag, "_sq_end"}, bus.int_img_sq[H-1][W-1], 0);
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] hold_img, hold_sq, hold_mid;
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.frame_clr = 1'b0; bus.img_ready = 1'b0;
    #12 rst = 1'b0;
    tick();
    chk("rst_vld", 32'(bus.img_valid), 0);
    chk("rst_rdy", 32'(bus.pix_ready), 1);
    chk("rst_img00", bus.int_img[0][0], 0);
    chk("rst_sq_end", bus.int_img_sq[H-1][W-1], 0);

    // all-2, back-to-back
    send_frame(0, 2, 0);
    chk("two_img00", bus.int_img[0][0], 2);
    chk("two_img_end", bus.int_img[H-1][W-1], 1152);
    chk("two_sq_end", bus.int_img_sq[H-1][W-1], 2304);
    check_image();
    release_img();

    // all-255 corner
    send_frame(0, 255, 0);
    chk("max_img_end", bus.int_img[H-1][W-1], 146880);
    chk("max_sq_end", bus.int_img_sq[H-1][W-1], 37454400);
    release_img();

    // ramp without and with gaps
    send_frame(1, 0, 0);
    check_image();
    release_img();
    send_frame(1, 0, 40);
    check_image();
    release_img();

    // random pixels with gaps, then backpressure with junk on pix_in
    send_frame(2, 0, 30);
    check_image();
    hold_img = ref_sum(H-1, W-1, 0);
    hold_sq  = ref_sum(H-1, W-1, 1);
    hold_mid = ref_sum(5, 7, 0);
    for (int k = 0; k < 50; k++) begin
      bus.pix_valid = 1'b1;
      bus.pix_in    = PW'($urandom);
      bus.frame_clr = (k == 20);
      tick();
      chk("bp_rdy", 32'(bus.pix_ready), 0);
      chk("bp_vld", 32'(bus.img_valid), 1);
      chk("bp_img_end", bus.int_img[H-1][W-1], hold_img);
      chk("bp_sq_end", bus.int_img_sq[H-1][W-1], hold_sq);
      chk("bp_img_mid", bus.int_img[5][7], hold_mid);
    end
    bus.pix_valid = 1'b0; bus.frame_clr = 1'b0;
    release_img();
    send_frame(0, 1, 0);
    chk("ones_img_end", bus.int_img[H-1][W-1], 576);
    chk("ones_sq_end", bus.int_img_sq[H-1][W-1], 576);

    // frame_clr together with img_ready in DONE: handshake still completes
    bus.frame_clr = 1'b1;
    release_img();
    bus.frame_clr = 1'b0;

    // frame_clr after 100 pixels, colliding with a valid pixel
    send_partial(100);
    bus.pix_valid = 1'b1; bus.pix_in = 8'd200; bus.frame_clr = 1'b1;
    tick();
    bus.pix_valid = 1'b0; bus.frame_clr = 1'b0;
    chk("clr_rdy", 32'(bus.pix_ready), 1);
    send_frame(0, 3, 20);
    chk("three_img_end", bus.int_img[H-1][W-1], 1728);
    chk("three_sq_end", bus.int_img_sq[H-1][W-1], 5184);
    check_image();
    release_img();

    // async reset mid-frame, then during DONE
    send_partial(50);
    async_reset("rst_fill");
    send_frame(2, 0, 20);
    check_image();
    async_reset("rst_done");
    send_frame(2, 0, 0);
    check_image();
    release_img();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
